// File: rtl/tia_hsync_sequencer_pkg.sv
// Shared decode indices, line length and LFSR step function for the
// TIA horizontal sync sequencer and its hcount LFSR.
package tia_hsync_sequencer_pkg;

    localparam logic [5:0] HS_SET      = 6'd4;
    localparam logic [5:0] HS_RST      = 6'd8;
    localparam logic [5:0] HB_END      = 6'd16;
    localparam logic [5:0] HB_END_LATE = 6'd18;
    localparam logic [5:0] LINE_LAST   = 6'd56;

    localparam logic [5:0] LFSR_RELOAD = 6'b000000;

    localparam logic [1:0] PHASE_PHI1  = 2'd1;
    localparam logic [1:0] PHASE_PHI2  = 2'd3;

    // XNOR feedback keeps the all-zero reload value inside the sequence.
    function automatic logic [5:0] lfsr_next(input logic [5:0] q);
        return {q[4:0], q[5] ~^ q[4]};
    endfunction

endpackage

// File: rtl/tia_hcount_lfsr.sv
// Six-bit horizontal counter LFSR; reload wins over advance so a line
// restart and a wrap both land on the all-zero state.
module tia_hcount_lfsr
    import tia_hsync_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       reload,
    output logic [5:0] q
);

    logic [5:0] q_q;
    logic [5:0] q_d;

    always_comb begin
        q_d = q_q;
        if (reload) begin
            q_d = LFSR_RELOAD;
        end else if (advance) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= LFSR_RELOAD;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tia_hsync_sequencer.sv
// TIA horizontal sequencer: two-phase clock enables, 57-step line counter,
// hsync/hblank decodes, HMOVE extended-blank latch and WSYNC CPU halt.
module tia_hsync_sequencer
    import tia_hsync_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rsync_strobe,
    input  logic       wsync_strobe,
    input  logic       hmove_strobe,
    output logic       hphi1,
    output logic       hphi2,
    output logic [5:0] hcount,
    output logic       hsync,
    output logic       hblank,
    output logic       rdy
);

    logic [1:0] phase_q;
    logic [1:0] phase_d;
    logic [5:0] step_q;
    logic [5:0] step_d;
    logic       hmove_q;
    logic       hmove_d;
    logic       ext_blank_q;
    logic       ext_blank_d;
    logic       rdy_q;
    logic       rdy_d;

    logic       advance;
    logic       wrap;
    logic       lfsr_reload;
    logic [5:0] lfsr_q;

    assign advance     = (phase_q == PHASE_PHI2);
    assign wrap        = advance && (step_q == LINE_LAST);
    assign lfsr_reload = rsync_strobe || wrap;

    // The HMOVE latch is consumed at the wrap: its value becomes the
    // extended-blank flag for the line that is starting.
    always_comb begin
        phase_d     = phase_q + 2'd1;
        step_d      = step_q;
        hmove_d     = hmove_q;
        ext_blank_d = ext_blank_q;
        rdy_d       = rdy_q;
        if (rsync_strobe) begin
            phase_d     = 2'd0;
            step_d      = 6'd0;
            hmove_d     = 1'b0;
            ext_blank_d = 1'b0;
            rdy_d       = 1'b1;
        end else begin
            if (advance) begin
                step_d = wrap ? 6'd0 : step_q + 6'd1;
            end
            if (wrap) begin
                ext_blank_d = hmove_q || hmove_strobe;
                hmove_d     = 1'b0;
                rdy_d       = 1'b1;
            end
            if (hmove_strobe) begin
                hmove_d = 1'b1;
            end
            if (wsync_strobe) begin
                rdy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= 2'd0;
            step_q      <= 6'd0;
            hmove_q     <= 1'b0;
            ext_blank_q <= 1'b0;
            rdy_q       <= 1'b1;
        end else begin
            phase_q     <= phase_d;
            step_q      <= step_d;
            hmove_q     <= hmove_d;
            ext_blank_q <= ext_blank_d;
            rdy_q       <= rdy_d;
        end
    end

    tia_hcount_lfsr u_hcount_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .reload  (lfsr_reload),
        .q       (lfsr_q)
    );

    assign hphi1  = (phase_q == PHASE_PHI1);
    assign hphi2  = (phase_q == PHASE_PHI2);
    assign hcount = lfsr_q;
    assign hsync  = (step_q >= HS_SET) && (step_q < HS_RST);
    assign hblank = (step_q < HB_END) || (ext_blank_q && (step_q < HB_END_LATE));
    assign rdy    = rdy_q;

endmodule
